// File: rtl/rv32i_pkg.sv
// Shared types for the sequential RV32 M-extension unit: width, op codes
// (identical to instruction funct3) and the visible FSM state.
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between a requester (master) and muldiv_seq (slave).
// Handshake: a transfer happens on a rising edge where valid && ready; once
// valid is raised the payload stays stable until that edge.
interface muldiv_seq_if;
  import rv32i_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply on {hi,lo} (multiplier in lo),
// or restoring shift-subtract divide (remainder in hi, dividend/quotient in lo).
module muldiv_step
  import rv32i_pkg::*;
(
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_hi} + {1'b0, (i_lo[0] ? i_opnd : '0)};
    w_shift = {i_hi, i_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_opnd};
    o_hi    = w_sum[XLEN:1];
    o_lo    = {w_sum[0], i_lo[XLEN-1:1]};
    if (i_is_div) begin
      // Top bit of the difference is the borrow: set means restore.
      if (!w_diff[XLEN]) begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_shift[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32 M unit: operands reduced to magnitudes, XLEN radix-2 steps,
// then sign fix and word select. Divide-by-zero / signed overflow may skip CALC.
module muldiv_seq
  import rv32i_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus,
  output logic          busy,
  output muldiv_state_e o_dbg_state
);

  muldiv_state_e   r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  mop_e            r_op;
  logic            r_neg_a, r_neg_b, r_b_zero;
  logic [XLEN-1:0] r_opnd, r_hi, r_lo, r_result;

  logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_early;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_early_res;
  logic [XLEN-1:0] w_step_hi, w_step_lo, w_quot, w_rem, w_fix_res;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  assign w_a_neg = op_a_signed(bus.req_op) && bus.req_a[XLEN-1];
  assign w_b_neg = op_b_signed(bus.req_op) && bus.req_b[XLEN-1];
  assign w_mag_a = w_a_neg ? -bus.req_a : bus.req_a;
  assign w_mag_b = w_b_neg ? -bus.req_b : bus.req_b;
  assign w_div0  = op_is_div(bus.req_op) && (bus.req_b == '0);
  assign w_ovf   = ((bus.req_op == OP_DIV) || (bus.req_op == OP_REM)) &&
                   (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1);
  assign w_early = EARLY_OUT && (w_div0 || w_ovf);
  // req_op[1] separates REM/REMU from DIV/DIVU among divide ops.
  assign w_early_res = bus.req_op[1] ? (w_div0 ? bus.req_a : '0)
                                     : (w_div0 ? '1 : bus.req_a);

  muldiv_step u_step (
    .i_is_div (op_is_div(r_op)),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_opnd   (r_opnd),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quot     = r_b_zero ? '1 : ((r_neg_a ^ r_neg_b) ? -r_lo : r_lo);
  assign w_rem      = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    unique case (r_op)
      OP_MUL:                      w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_fix_res = w_quot;
      default:                     w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.req_valid) w_next = w_early ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      default: if (bus.resp_ready) w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b_zero <= 1'b0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (bus.req_valid) begin
          r_op     <= mop_e'(bus.req_op);
          r_neg_a  <= w_a_neg;
          r_neg_b  <= w_b_neg;
          r_b_zero <= w_div0;
          r_cnt    <= '0;
          r_hi     <= '0;
          r_lo     <= op_is_div(bus.req_op) ? w_mag_a : w_mag_b;
          r_opnd   <= op_is_div(bus.req_op) ? w_mag_b : w_mag_a;
          if (w_early) r_result <= w_early_res;
        end
        ST_CALC: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= (r_cnt == CNT_W'(XLEN-1)) ? '0 : r_cnt + CNT_W'(1);
        end
        ST_FIX:  r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == ST_IDLE);
  assign bus.resp_valid  = (r_state == ST_DONE);
  assign bus.resp_result = r_result;
  assign busy            = (r_state != ST_IDLE);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: one instance with EARLY_OUT=1 and one with EARLY_OUT=0,
// directed corner cases plus random traffic against an arithmetic reference.
module tb_muldiv_seq;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy_e, busy_n;
  muldiv_state_e dbg_e, dbg_n;

  muldiv_seq_if bus_e ();
  muldiv_seq_if bus_n ();

  muldiv_seq #(.EARLY_OUT(1'b1)) dut_e (
    .clk(clk), .rst(rst), .bus(bus_e), .busy(busy_e), .o_dbg_state(dbg_e)
  );
  muldiv_seq #(.EARLY_OUT(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n), .busy(busy_n), .o_dbg_state(dbg_n)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int          exp_lat_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic and SV signed division.
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a;
            else return $signed(a) / $signed(b);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'd0;
            else return $signed(a) % $signed(b);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int model_lat(input bit early, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    bit is_div, is_sdiv, special;
    is_div  = (op >= 3'd4);
    is_sdiv = (op == 3'd4) || (op == 3'd6);
    special = is_div && ((b == 0) || (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (early && special) ? 1 : 34;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks (sel 0 = EARLY_OUT=1, sel 1 = EARLY_OUT=0) ----------------
  function automatic logic get_rdy(input bit sel);
    return sel ? bus_n.req_ready : bus_e.req_ready;
  endfunction
  function automatic logic get_rv(input bit sel);
    return sel ? bus_n.resp_valid : bus_e.resp_valid;
  endfunction
  function automatic logic [31:0] get_res(input bit sel);
    return sel ? bus_n.resp_result : bus_e.resp_result;
  endfunction

  task automatic set_req(input bit sel, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      bus_n.req_valid = v; bus_n.req_op = op; bus_n.req_a = a; bus_n.req_b = b;
    end else begin
      bus_e.req_valid = v; bus_e.req_op = op; bus_e.req_a = a; bus_e.req_b = b;
    end
  endtask

  task automatic set_rr(input bit sel, input logic v);
    if (sel) bus_n.resp_ready = v;
    else     bus_e.resp_ready = v;
  endtask

  // Returns just after the accept edge, with operands already scrambled.
  task automatic send_req(input bit sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!get_rdy(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!get_rdy(sel)) check("req_ready_timeout", 64'd0, 64'd1);
    set_req(sel, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    set_req(sel, 1'b0, 3'($urandom), $urandom, $urandom);
  endtask

  task automatic wait_resp(input bit sel, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!get_rv(sel) && lat < 200);
    if (!get_rv(sel)) check("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume(input bit sel);
    set_rr(sel, 1'b1);
    @(posedge clk);
    #1;
    set_rr(sel, 1'b0);
  endtask

  task automatic do_txn(input bit sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int lat;
    logic [31:0] got;
    exp_q.push_back(model_res(op, a, b));
    exp_lat_q.push_back(model_lat(!sel, op, a, b));
    send_req(sel, op, a, b);
    wait_resp(sel, lat);
    got = get_res(sel);
    check({tag, "_res"}, 64'(got), 64'(exp_q.pop_front()));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat_q.pop_front()));
    check({tag, "_rdy_lo"}, 64'(get_rdy(sel)), 64'd0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check({tag, "_hold"}, 64'(get_res(sel)), 64'(got));
    consume(sel);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus_e.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus_e.resp_valid), 64'd0);
    check("rst_busy", 64'(busy_e), 64'd0);
    check("rst_result", 64'(bus_e.resp_result), 64'd0);
    check("rst_n_req_ready", 64'(bus_n.req_ready), 64'd1);
    check("rst_n_result", 64'(bus_n.resp_result), 64'd0);
    rst = 1'b0;

    // Directed corner cases
    do_txn(0, 3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_txn(0, 3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    do_txn(0, 3'd5, 32'd7, 32'd0, "divu_by0_e");
    do_txn(0, 3'd7, 32'd7, 32'd0, "remu_by0_e");
    do_txn(1, 3'd5, 32'd7, 32'd0, "divu_by0_n");
    do_txn(1, 3'd7, 32'd7, 32'd0, "remu_by0_n");
    do_txn(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf_e");
    do_txn(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf_e");
    do_txn(1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf_n");
    do_txn(1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf_n");
    do_txn(1, 3'd4, 32'hFFFF_FFF9, 32'd0, "div_by0_neg_n");
    do_txn(1, 3'd6, 32'hFFFF_FFF9, 32'd0, "rem_by0_neg_n");
    do_txn(0, 3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    do_txn(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    do_txn(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    do_txn(0, 3'd0, 32'hFFFF_FFFD, 32'd5, "mul_m3_5");

    // Result held for 10 cycles with a competing request mid-window
    begin
      int lat;
      send_req(0, 3'd4, 32'hFFFF_FFF9, 32'd2);
      wait_resp(0, lat);
      check("hold_lat", 64'(lat), 64'd34);
      for (int i = 0; i < 10; i++) begin
        if (i == 3) set_req(0, 1'b1, 3'd0, 32'd6, 32'd7);
        @(negedge clk);
        check("hold_result", 64'(bus_e.resp_result), 64'hFFFF_FFFD);
        check("hold_req_ready", 64'(bus_e.req_ready), 64'd0);
        check("hold_resp_valid", 64'(bus_e.resp_valid), 64'd1);
      end
      set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
      consume(0);
      @(negedge clk);
      check("hold_no_accept_busy", 64'(busy_e), 64'd0);
    end

    // Asynchronous reset in the middle of CALC
    send_req(0, 3'd0, 32'd123, 32'd456);
    repeat (15) @(posedge clk);
    #2;
    check("midrst_state", 64'(dbg_e), 64'(ST_CALC));
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy_e), 64'd0);
    check("midrst_req_ready", 64'(bus_e.req_ready), 64'd1);
    check("midrst_resp_valid", 64'(bus_e.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_e.resp_valid) check("midrst_no_pulse", 64'd1, 64'd0);
    end
    check("midrst_idle_after", 64'(busy_e), 64'd0);
    do_txn(0, 3'd0, 32'd6, 32'd7, "mul_after_rst");

    // Random traffic
    for (int i = 0; i < 160; i++)
      do_txn(0, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), "rnd_e");
    for (int i = 0; i < 40; i++)
      do_txn(1, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), "rnd_n");

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: EARLY_OUT, default 1, when 1 divide-by-zero and signed overflow bypass CALC.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_op  input  3  operation, RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 req_a  input  XLEN  operand rs1.
REQ-008 req_b  input  XLEN  operand rs2.
REQ-009 resp_valid  output  1  result available; high only in DONE.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_result  output  XLEN  result; held stable while resp_valid is high.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States: IDLE, CALC, FIX, DONE; encoding is free.
REQ-014 IDLE: on req_valid && req_ready, latch op, operand magnitudes and sign flags, clear iteration counter, go to CALC. Otherwise stay.
REQ-015 CALC: one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; go to FIX after exactly XLEN steps (counter XLEN-1 -> 0 wrap).
REQ-016 FIX: apply sign correction; select low word (MUL), high word (MULH*), quotient (DIV*) or remainder (REM*); go to DONE.
REQ-017 DONE: hold resp_valid=1 and resp_result until resp_ready=1, then return to IDLE on the same edge.
REQ-018 Latency, accept edge to first resp_valid cycle: XLEN+2 cycles (34 at XLEN=32) for all normal operations.
REQ-019 Multiply: MULH treats both operands as signed, MULHSU treats a as signed and b as unsigned, MULHU treats both as unsigned. The product is the full 2*XLEN-bit value.
REQ-020 Divide-by-zero: quotient = all ones, remainder = req_a, for signed and unsigned ops.
REQ-021 Signed overflow (a = most-negative value, b = -1, DIV/REM): quotient = a, remainder = 0.
REQ-022 When EARLY_OUT=1, REQ-020/021 cases go IDLE -> DONE directly, latency 1. When EARLY_OUT=0, they traverse CALC and FIX with the same results.
REQ-023 Signed quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-024 req_valid while busy is ignored; no queuing. Operand changes after acceptance have no effect.
REQ-025 resp_valid and req_ready are never both high.

Reset
REQ-026 rst asserted at any time, including mid-CALC or in DONE, forces IDLE within the same cycle with no clock edge required. The in-flight result is discarded.
REQ-027 Reset values: req_ready=1, resp_valid=0, busy=0, resp_result=0, counter=0, accumulators=0.
REQ-028 After rst deasserts, a request is accepted on the first rising edge at which req_valid=1.

Structure
REQ-029 XLEN and an enum for the 3-bit M-op codes belong in rv32i_pkg. The state enum also belongs in rv32i_pkg for debug visibility.
REQ-030 No sub-module is required. An optional sub-module, muldiv_step, holds the single-cycle add/subtract-shift datapath.
REQ-031 Operation codes are the same as instruction funct3, so the decoder passes funct3 unchanged.

Verification
REQ-032 DIV a=-7, b=2 -> resp_result=0xFFFFFFFD (-3) exactly 34 cycles after acceptance; REM with the same operands -> 0xFFFFFFFF (-1).
REQ-033 DIVU a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7. Each arrives 1 cycle after acceptance with EARLY_OUT=1 and 34 cycles after with EARLY_OUT=0.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-035 MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF; MUL a=-3, b=5 -> 0xFFFFFFF1.
REQ-036 Hold resp_ready=0 for 10 cycles in DONE -> resp_result stays stable and req_ready stays 0. A new req_valid issued during that window is not accepted.
REQ-037 Assert rst at CALC cycle 15 -> busy=0 and req_ready=1 immediately, resp_valid never pulses. The next MUL a=6, b=7 returns 42.
